// File: rtl/uart_tx_axis.sv
// UART transmitter fed by a valid/ready stream; one frame per accepted word.
// Frame: start bit, data LSB first, optional parity, then 1 or 2 stop bits.
module uart_tx_axis #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 868,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = $clog2(DATA_WIDTH);

    localparam logic [TW-1:0] T_LAST  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_PRE   = TW'(CLK_DIV - 2);
    localparam logic [IW-1:0] I_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] S_LAST  = IW'(STOP_BITS - 1);
    localparam logic          PAR_INV = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  txd_q, txd_d;
    logic                  done_q, done_d;
    logic                  tick_s;
    logic                  parity_s;
    logic [IW-1:0]         idx_inc_s;

    assign tick_s    = (timer_q == T_LAST);
    assign parity_s  = (^data_q) ^ PAR_INV;
    assign idx_inc_s = idx_q + IW'(1);

    // Next-state logic; txd_d is the line level for the following cycle.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        data_d  = data_q;
        txd_d   = txd_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (s_valid) begin
                    data_d  = s_data;
                    state_d = S_START;
                    timer_d = '0;
                    idx_d   = '0;
                    txd_d   = 1'b0;
                end else begin
                    timer_d = '0;
                end
            end
            S_START: begin
                if (tick_s) begin
                    state_d = S_DATA;
                    timer_d = '0;
                    idx_d   = '0;
                    txd_d   = data_q[0];
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                if (tick_s) begin
                    timer_d = '0;
                    if (idx_q == I_LAST) begin
                        idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            txd_d   = parity_s;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        idx_d = idx_inc_s;
                        txd_d = data_q[idx_inc_s];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_PARITY: begin
                if (tick_s) begin
                    state_d = S_STOP;
                    timer_d = '0;
                    idx_d   = '0;
                    txd_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_STOP: begin
                // idx_q counts stop bits here; done is registered one cycle ahead
                done_d = (timer_q == T_PRE) && (idx_q == S_LAST);
                if (tick_s) begin
                    timer_d = '0;
                    if (idx_q == S_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_inc_s;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
                txd_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                idx_d   = '0;
                txd_d   = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    assign s_ready = (state_q == S_IDLE);
    assign busy    = ~s_ready;
    assign txd     = txd_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_axis.sv
// Bench for uart_tx_axis: four parameter variants, cycle-exact frame table,
// serial-line monitors decoding frames against a scoreboard queue.
module tb_uart_tx_axis;

    localparam int PE_A[4]  = '{0, 1, 1, 0};
    localparam int ODD_A[4] = '{0, 0, 1, 0};
    localparam int SB_A[4]  = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sv, rdy, txd, bsy, done;
    logic [7:0] sd [4];

    int total = 0;
    int bad   = 0;

    logic [7:0] q0[$], q1[$], q2[$], q3[$];

    typedef struct {
        int          u;
        logic [7:0]  d;
        int          nb;
        logic [11:0] frm;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    uart_tx_axis #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_d0 (
        .clk(clk), .rst(rst), .s_valid(sv[0]), .s_data(sd[0]), .s_ready(rdy[0]),
        .txd(txd[0]), .busy(bsy[0]), .tx_done(done[0]));
    uart_tx_axis #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_d1 (
        .clk(clk), .rst(rst), .s_valid(sv[1]), .s_data(sd[1]), .s_ready(rdy[1]),
        .txd(txd[1]), .busy(bsy[1]), .tx_done(done[1]));
    uart_tx_axis #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_d2 (
        .clk(clk), .rst(rst), .s_valid(sv[2]), .s_data(sd[2]), .s_ready(rdy[2]),
        .txd(txd[2]), .busy(bsy[2]), .tx_done(done[2]));
    uart_tx_axis #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d3 (
        .clk(clk), .rst(rst), .s_valid(sv[3]), .s_data(sd[3]), .s_ready(rdy[3]),
        .txd(txd[3]), .busy(bsy[3]), .tx_done(done[3]));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int u, input logic [7:0] d);
        case (u)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            3: q3.push_back(d);
            default: ;
        endcase
    endtask

    task automatic pop_exp(input int u, output bit ok, output logic [7:0] d);
        ok = 1'b0;
        d  = 8'h00;
        case (u)
            0: if (q0.size() > 0) begin d = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin d = q1.pop_front(); ok = 1'b1; end
            2: if (q2.size() > 0) begin d = q2.pop_front(); ok = 1'b1; end
            3: if (q3.size() > 0) begin d = q3.pop_front(); ok = 1'b1; end
            default: ;
        endcase
    endtask

    // Raise s_valid and return just after the posedge that completes the handshake.
    task automatic do_hs(input int u, input logic [7:0] d);
        bit got = 1'b0;
        @(negedge clk);
        sv[u] = 1'b1;
        sd[u] = d;
        for (int i = 0; i < 300 && !got; i++) begin
            if (rdy[u]) begin
                @(posedge clk);
                push_exp(u, d);
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) chk($sformatf("hs_timeout u%0d", u), 0, 1);
    endtask

    // Cycle-exact check of one frame; cycle 1 is the cycle after the handshake edge.
    task automatic chk_frame(input int u, input logic [11:0] frm, input int nb, input bit drop);
        logic e;
        for (int c = 1; c <= nb * 4 + 1; c++) begin
            @(negedge clk);
            if (c == 1 && drop) sv[u] = 1'b0;
            e = (c <= nb * 4) ? frm[(c - 1) / 4] : 1'b1;
            chk($sformatf("txd u%0d c%0d", u, c), int'(txd[u]), int'(e));
            chk($sformatf("tx_done u%0d c%0d", u, c), int'(done[u]), int'(c == nb * 4));
            chk($sformatf("s_ready u%0d c%0d", u, c), int'(rdy[u]), int'(c == nb * 4 + 1));
            chk($sformatf("busy u%0d c%0d", u, c), int'(bsy[u]), int'(c <= nb * 4));
        end
    endtask

    // Serial-line decoder: samples mid-bit and checks against the scoreboard.
    task automatic mon(input int u);
        logic        prev = 1'b1;
        logic [11:0] bits;
        logic [7:0]  e;
        bit          ok, abort;
        int          nb;
        forever begin
            @(negedge clk);
            if (!rst && prev && !txd[u]) begin
                abort = 1'b0;
                bits  = '0;
                nb    = 9 + PE_A[u] + SB_A[u];
                for (int k = 0; k < nb && !abort; k++) begin
                    for (int w = 0; w < ((k == 0) ? 1 : 4) && !abort; w++) begin
                        @(negedge clk);
                        if (rst) abort = 1'b1;
                    end
                    if (!abort) bits[k] = txd[u];
                end
                pop_exp(u, ok, e);
                if (!abort) begin
                    chk($sformatf("mon_unexpected u%0d", u), int'(ok), 1);
                    chk($sformatf("mon_start u%0d", u), int'(bits[0]), 0);
                    chk($sformatf("mon_data u%0d", u), int'(bits[8:1]), int'(e));
                    if (PE_A[u] != 0)
                        chk($sformatf("mon_parity u%0d", u), int'(bits[9]), int'((^e) ^ ODD_A[u][0]));
                    for (int s = 0; s < SB_A[u]; s++)
                        chk($sformatf("mon_stop u%0d", u), int'(bits[9 + PE_A[u] + s]), 1);
                end
            end
            prev = txd[u];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int lows, rdy_lows;
        bit seen;

        tbl[0] = '{0, 8'hA5, 10, 12'b00_1101001010};
        tbl[1] = '{0, 8'h00, 10, 12'b00_1000000000};
        tbl[2] = '{0, 8'hFF, 10, 12'b00_1111111110};
        tbl[3] = '{1, 8'h07, 11, 12'b0_11000001110};
        tbl[4] = '{2, 8'h07, 11, 12'b0_10000001110};
        tbl[5] = '{1, 8'h5A, 11, 12'b0_10010110100};
        tbl[6] = '{2, 8'h00, 11, 12'b0_11000000000};
        tbl[7] = '{3, 8'h3C, 11, 12'b0_11001111000};
        tbl[8] = '{0, 8'h5A, 10, 12'b00_1010110100};

        rst = 1'b1;
        sv  = 4'b0000;
        for (int u = 0; u < 4; u++) sd[u] = 8'h00;
        fork
            mon(0);
            mon(1);
            mon(2);
            mon(3);
        join_none

        repeat (3) @(negedge clk);
        chk("rst_txd", int'(txd), 15);
        chk("rst_ready", int'(rdy), 15);
        chk("rst_busy", int'(bsy), 0);
        chk("rst_done", int'(done), 0);
        #2 rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_hs(tbl[i].u, tbl[i].d);
            chk_frame(tbl[i].u, tbl[i].frm, tbl[i].nb, 1'b1);
        end

        // back-to-back: s_valid held high; s_data changes mid-frame
        do_hs(0, 8'h00);
        seen = 1'b0;
        c = 0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) sd[0] = 8'hFF;
            if (i == 40) chk("b2b_stop_c40", int'(txd[0]), 1);
            if (rdy[0]) begin
                seen = 1'b1;
                c = i;
            end
        end
        chk("b2b_gap", c, 41);
        chk("b2b_idle_txd", int'(txd[0]), 1);
        @(posedge clk);
        push_exp(0, 8'hFF);
        @(negedge clk);
        sv[0] = 1'b0;
        chk("b2b_second_start", int'(txd[0]), 0);
        chk("b2b_second_busy", int'(bsy[0]), 1);
        repeat (45) @(negedge clk);

        // reset during DATA bit 3 of 0xC3, then handshake on first edge after release
        do_hs(0, 8'hC3);
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == 1) sv[0] = 1'b0;
        end
        chk("pre_rst_bit3", int'(txd[0]), 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_txd", int'(txd[0]), 1);
        chk("midrst_ready", int'(rdy[0]), 1);
        chk("midrst_busy", int'(bsy[0]), 0);
        chk("midrst_done", int'(done[0]), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        sv[0] = 1'b1;
        sd[0] = 8'h5A;
        push_exp(0, 8'h5A);
        @(posedge clk);
        chk_frame(0, tbl[8].frm, 10, 1'b1);

        // upstream stall: data and valid wiggle while busy, then 100 idle cycles
        do_hs(0, 8'h96);
        lows = 0;
        for (int i = 1; i <= 41; i++) begin
            @(negedge clk);
            sd[0] = ~sd[0];
            sv[0] = (i < 38) ? ~sv[0] : 1'b0;
            if (i == 40) chk("stall_done_c40", int'(done[0]), 1);
        end
        lows = 0;
        rdy_lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            sd[0] = ~sd[0];
            if (!txd[0]) lows++;
            if (!rdy[0]) rdy_lows++;
        end
        chk("stall_txd_low_cycles", lows, 0);
        chk("stall_spurious_hs", rdy_lows, 0);

        repeat (20) @(negedge clk);
        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);
        chk("q2_left", q2.size(), 0);
        chk("q3_left", q3.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
